// File: rtl/dmem_if.sv
// Memory-stage request/response bundle between the pipeline (master) and the
// data-memory responder (slave).
interface dmem_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              stall;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, stall
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, stall
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one request at a time, fixed read/write
// wait states, stall for the hazard unit, and a saturating stall-cycle counter.
//
//   state  | meaning
//   IDLE   | ready; accepts a request when req_valid is high
//   WAIT   | counting down wait states for the captured request
//   RESP   | one-cycle response; write commits on the edge leaving it
module dmem_responder #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    dmem_if.slave       bus,
    output logic [15:0] busy_cycles_o
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] RD_CNT = 4'(RD_LAT - 1);
    localparam logic [3:0] WR_CNT = 4'(WR_LAT - 1);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [15:0]       busy_q, busy_d;
    logic              stall;
    logic [3:0]        load_cnt;

    assign load_cnt = bus.req_write ? WR_CNT : RD_CNT;

    // During the reset cycle the outputs already look like IDLE.
    assign stall = rst_i ? bus.req_valid
                         : ((state_q == S_IDLE) && bus.req_valid) || (state_q == S_WAIT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    wr_d    = bus.req_write;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    cnt_d   = load_cnt;
                    if (load_cnt == 4'd0) begin
                        state_d = S_RESP;
                        if (!bus.req_write) rdata_d = mem_q[bus.req_addr];
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    if (!wr_q) rdata_d = mem_q[addr_q];
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (stall && (busy_q != 16'hFFFF)) ? busy_q + 16'd1 : busy_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            busy_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
        end
    end

    // Storage is never cleared; a write still pending when reset hits is dropped.
    always_ff @(posedge clk_i) begin
        if (!rst_i && (state_q == S_RESP) && wr_q) mem_q[addr_q] <= wdata_q;
    end

    assign bus.req_ready  = rst_i || (state_q == S_IDLE);
    assign bus.rsp_valid  = !rst_i && (state_q == S_RESP);
    assign bus.rsp_rdata  = rdata_q;
    assign bus.stall      = stall;
    assign busy_cycles_o  = busy_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a cycle table on a RD_LAT=2/WR_LAT=1 instance and
// hand sequences on a RD_LAT=15/WR_LAT=3 instance for reset, capture and saturation.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    logic [15:0] busy_a, busy_b;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dmem_if #(.ADDR_W(8), .DATA_W(32)) ifa ();
    dmem_if #(.ADDR_W(8), .DATA_W(32)) ifb ();

    dmem_responder #(.ADDR_W(8), .DATA_W(32), .RD_LAT(2), .WR_LAT(1)) dut_a (
        .clk_i(clk), .rst_i(rst_a), .bus(ifa), .busy_cycles_o(busy_a));

    dmem_responder #(.ADDR_W(8), .DATA_W(32), .RD_LAT(15), .WR_LAT(3)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .bus(ifb), .busy_cycles_o(busy_b));

    typedef struct {
        logic        v;
        logic        w;
        logic [7:0]  a;
        logic [31:0] d;
        logic        e_ready;
        logic        e_rv;
        logic        e_stall;
        logic        chk_rd;
        logic [31:0] e_rd;
        logic [15:0] e_busy;
    } vec_t;

    vec_t vecs [17];

    function automatic vec_t mk(logic v, logic w, logic [7:0] a, logic [31:0] d,
                                logic rdy, logic rv, logic st, logic crd,
                                logic [31:0] erd, logic [15:0] eb);
        vec_t t;
        t.v = v; t.w = w; t.a = a; t.d = d;
        t.e_ready = rdy; t.e_rv = rv; t.e_stall = st;
        t.chk_rd = crd; t.e_rd = erd; t.e_busy = eb;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // One request on instance B; returns read data and the response latency.
    task automatic b_txn(input logic wr, input logic [7:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output int lat);
        ifb.req_valid = 1'b1;
        ifb.req_write = wr;
        ifb.req_addr  = a;
        ifb.req_wdata = d;
        lat = -1;
        rd  = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ifb.rsp_valid) begin
                rd  = ifb.rsp_rdata;
                lat = c;
                break;
            end
            @(posedge clk); #1;
            ifb.req_valid = 1'b0;
        end
        @(posedge clk); #1;
        ifb.req_valid = 1'b0;
    endtask

    logic [31:0] rd;
    int          lat;
    logic        seen;
    int          model;
    logic        wrapped;
    logic [15:0] prev;

    initial begin
        vecs[0]  = mk(0,0,8'h00,32'h0,        1,0,0,1,32'h0,0);
        vecs[1]  = mk(1,1,8'h10,32'hDEADBEEF, 1,0,1,1,32'h0,0);
        vecs[2]  = mk(1,0,8'h10,32'h0,        0,1,0,1,32'h0,1);
        vecs[3]  = mk(1,0,8'h10,32'h0,        1,0,1,1,32'h0,1);
        vecs[4]  = mk(1,0,8'h10,32'h0,        0,0,1,1,32'h0,2);
        vecs[5]  = mk(1,1,8'h00,32'hA5A50000, 0,1,0,1,32'hDEADBEEF,3);
        vecs[6]  = mk(1,1,8'h00,32'hA5A50000, 1,0,1,1,32'hDEADBEEF,3);
        vecs[7]  = mk(1,1,8'hFF,32'h0FF0FFFF, 0,1,0,1,32'hDEADBEEF,4);
        vecs[8]  = mk(1,1,8'hFF,32'h0FF0FFFF, 1,0,1,1,32'hDEADBEEF,4);
        vecs[9]  = mk(1,0,8'h00,32'h0,        0,1,0,1,32'hDEADBEEF,5);
        vecs[10] = mk(1,0,8'h00,32'h0,        1,0,1,1,32'hDEADBEEF,5);
        vecs[11] = mk(1,0,8'h00,32'h0,        0,0,1,1,32'hDEADBEEF,6);
        vecs[12] = mk(1,0,8'hFF,32'h0,        0,1,0,1,32'hA5A50000,7);
        vecs[13] = mk(1,0,8'hFF,32'h0,        1,0,1,1,32'hA5A50000,7);
        vecs[14] = mk(1,0,8'hFF,32'h0,        0,0,1,1,32'hA5A50000,8);
        vecs[15] = mk(0,0,8'h00,32'h0,        0,1,0,1,32'h0FF0FFFF,9);
        vecs[16] = mk(0,0,8'h00,32'h0,        1,0,0,1,32'h0FF0FFFF,9);

        rst_a = 1'b1; rst_b = 1'b1;
        ifa.req_valid = 1'b0; ifa.req_write = 1'b0; ifa.req_addr = '0; ifa.req_wdata = '0;
        ifb.req_valid = 1'b0; ifb.req_write = 1'b0; ifb.req_addr = '0; ifb.req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_ready", {31'b0, ifa.req_ready}, 1);
        chk("rst_rv",    {31'b0, ifa.rsp_valid}, 0);
        chk("rst_stall", {31'b0, ifa.stall}, 0);
        @(posedge clk); #1;
        rst_a = 1'b0;

        // Tests 1-3: write/read-after-write, back-to-back reads, top address
        for (int i = 0; i < 17; i++) begin
            ifa.req_valid = vecs[i].v;
            ifa.req_write = vecs[i].w;
            ifa.req_addr  = vecs[i].a;
            ifa.req_wdata = vecs[i].d;
            @(negedge clk);
            chk($sformatf("vec%0d_ready", i), {31'b0, ifa.req_ready}, {31'b0, vecs[i].e_ready});
            chk($sformatf("vec%0d_rv", i),    {31'b0, ifa.rsp_valid}, {31'b0, vecs[i].e_rv});
            chk($sformatf("vec%0d_stall", i), {31'b0, ifa.stall},     {31'b0, vecs[i].e_stall});
            chk($sformatf("vec%0d_busy", i),  {16'b0, busy_a},        {16'b0, vecs[i].e_busy});
            if (vecs[i].chk_rd)
                chk($sformatf("vec%0d_rdata", i), ifa.rsp_rdata, vecs[i].e_rd);
            @(posedge clk); #1;
        end

        // Test 4: reset during WAIT drops the pending write
        rst_b = 1'b0;
        b_txn(1'b1, 8'h20, 32'h11112222, rd, lat);
        chk("wr3_lat", lat, 3);
        ifb.req_valid = 1'b1; ifb.req_write = 1'b1;
        ifb.req_addr = 8'h20; ifb.req_wdata = 32'h12345678;
        @(negedge clk);
        chk("t4_accept_stall", {31'b0, ifb.stall}, 1);
        @(posedge clk); #1;
        ifb.req_valid = 1'b0;
        @(negedge clk);
        chk("t4_wait_ready", {31'b0, ifb.req_ready}, 0);
        @(posedge clk); #1;
        rst_b = 1'b1;
        @(negedge clk);
        chk("t4_rstcyc_ready", {31'b0, ifb.req_ready}, 1);
        chk("t4_rstcyc_rv",    {31'b0, ifb.rsp_valid}, 0);
        @(posedge clk); #1;
        rst_b = 1'b0;
        @(negedge clk);
        chk("t4_busy_zero", {16'b0, busy_b}, 0);
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ifb.rsp_valid) seen = 1'b1;
        end
        chk("t4_no_rsp", {31'b0, seen}, 0);
        @(posedge clk); #1;
        b_txn(1'b0, 8'h20, 32'h0, rd, lat);
        chk("t4_rd_lat", lat, 15);
        chk("t4_rd_data", rd, 32'h11112222);

        // Test 5: request fields changing after acceptance are ignored
        b_txn(1'b1, 8'h31, 32'h31313131, rd, lat);
        ifb.req_valid = 1'b1; ifb.req_write = 1'b1;
        ifb.req_addr = 8'h30; ifb.req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        ifb.req_valid = 1'b0;
        ifb.req_addr  = 8'h31;
        ifb.req_wdata = 32'hBAD0BAD0;
        lat = -1;
        for (int c = 1; c < 10; c++) begin
            @(negedge clk);
            if (ifb.rsp_valid) begin lat = c; break; end
            @(posedge clk); #1;
        end
        chk("t5_wr_lat", lat, 3);
        @(posedge clk); #1;
        b_txn(1'b0, 8'h30, 32'h0, rd, lat);
        chk("t5_rd30", rd, 32'hCAFEF00D);
        b_txn(1'b0, 8'h31, 32'h0, rd, lat);
        chk("t5_rd31", rd, 32'h31313131);

        // Test 6: busy_cycles saturation under continuous reads
        rst_b = 1'b1;
        @(posedge clk); #1;
        rst_b = 1'b0;
        ifb.req_valid = 1'b1; ifb.req_write = 1'b0; ifb.req_addr = 8'h00;
        model = 0; wrapped = 1'b0; prev = 16'd0;
        for (int c = 0; c < 70000; c++) begin
            @(negedge clk);
            if (busy_b < prev) wrapped = 1'b1;
            prev = busy_b;
            if (ifb.stall) model++;
        end
        @(posedge clk); #1;
        ifb.req_valid = 1'b0;
        @(negedge clk);
        chk("t6_model_sat", {31'b0, (model >= 65535)}, 1);
        chk("t6_busy_sat", {16'b0, busy_b}, 32'h0000FFFF);
        chk("t6_no_wrap", {31'b0, wrapped}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
